// File: rtl/button_event_fsm_pkg.sv
// Shared types for the button gesture classifier.
// Event codes, FSM states and a sizing helper.
package button_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND_PRESSED
  } btn_state_t;

  typedef enum logic [1:0] {
    EVT_REPEAT = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_DOUBLE = 2'b11
  } evt_code_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int max3(int a, int b, int c);
    return max2(max2(a, b), c);
  endfunction

endpackage

// File: rtl/button_event_fsm_if.sv
// Event output slot bundle: valid/ready handshake
// plus the sticky drop flag.
interface button_event_fsm_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/button_event_fsm_evt_slot.sv
// Single-entry event register with valid/ready
// and a sticky overflow flag for dropped events.
module evt_slot
  import button_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  evt_code_t  i_code,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic       o_overflow
);

  logic       r_valid;
  logic [1:0] r_code;
  logic       r_ovf;

  // Load on push, drop if full and not draining, clear on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= 2'b00;
      r_ovf   <= 1'b0;
    end else if (i_push) begin
      if (r_valid && !i_ready) begin
        r_ovf <= 1'b1;
      end else begin
        r_valid <= 1'b1;
        r_code  <= i_code;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_code     = r_code;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/button_event_fsm.sv
// Classifies debounced button gestures as short, long or double.
// Define HOLD_REPEAT_EN for auto-repeat events while held long.
module button_event_fsm
  import button_evt_pkg::*;
#(
  parameter int FPGA_CLK    = 50000000,
  parameter int LONG_MS     = 1000,
  parameter int GAP_MS      = 300,
  parameter int LONG_CYCLES = FPGA_CLK / 1000 * LONG_MS,
  parameter int GAP_CYCLES  = FPGA_CLK / 1000 * GAP_MS,
`ifdef HOLD_REPEAT_EN
  parameter int REPEAT_CYCLES = FPGA_CLK / 10,
  parameter int CNT_BITS =
    $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1)
`else
  parameter int CNT_BITS =
    $clog2(max2(LONG_CYCLES, GAP_CYCLES) + 1)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_level,
  button_event_fsm_if.master  evt
);

  localparam logic [CNT_BITS-1:0] LONG_LAST =
    CNT_BITS'(LONG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] GAP_LAST =
    CNT_BITS'(GAP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE =
    CNT_BITS'(1);
`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_BITS-1:0] REP_LAST =
    CNT_BITS'(REPEAT_CYCLES - 1);
`endif

  btn_state_t          r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_btn_q;
  logic                r_push;
  evt_code_t           r_code;

  logic w_rise;
  logic w_fall;

  assign w_rise = btn_level & ~r_btn_q;
  assign w_fall = ~btn_level & r_btn_q;

  // Gesture FSM; release beats a same-cycle timeout in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_btn_q <= 1'b0;
      r_push  <= 1'b0;
      r_code  <= EVT_REPEAT;
    end else begin
      r_btn_q <= btn_level;
      r_push  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end
        end
        PRESSED: begin
          if (w_fall) begin
            r_state <= WAIT_GAP;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= LONG_HELD;
            r_cnt   <= '0;
            r_push  <= 1'b1;
            r_code  <= EVT_LONG;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        LONG_HELD: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_cnt   <= '0;
`ifdef HOLD_REPEAT_EN
          end else if (r_cnt == REP_LAST) begin
            r_cnt  <= '0;
            r_push <= 1'b1;
            r_code <= EVT_REPEAT;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
`endif
          end
        end
        WAIT_GAP: begin
          if (w_rise) begin
            r_state <= SECOND_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_push  <= 1'b1;
            r_code  <= EVT_SHORT;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        SECOND_PRESSED: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_push  <= 1'b1;
            r_code  <= EVT_DOUBLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  evt_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_push),
    .i_code     (r_code),
    .i_ready    (evt.evt_ready),
    .o_valid    (evt.evt_valid),
    .o_code     (evt.evt_code),
    .o_overflow (evt.evt_overflow)
  );

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: gesture table, corner sequences,
// random waveforms vs. a run-length gesture model.
module tb_button_event_fsm;

  localparam int LC = 20;
  localparam int GC = 10;
  localparam int RC = 8;
  localparam int NC = 3000;

  logic clk = 1'b0;
  logic rst;
  logic btn;

  button_event_fsm_if evt();

  button_event_fsm #(
    .LONG_CYCLES   (LC),
`ifdef HOLD_REPEAT_EN
    .REPEAT_CYCLES (RC),
`endif
    .GAP_CYCLES    (GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn),
    .evt       (evt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 1'b0;
    evt.evt_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int h1;
    int g;
    int h2;
    int exp_k;
    int exp_code;
    int exp_n;
  } vec_t;

  vec_t tbl[11];

  bit b[NC];
  int ev[NC];
  int ps[$];
  int pl[$];

  initial begin
    int first, code, n, t;
    int ek[$];
    int ec[$];
    int gk[$];
    int gc[$];
    bit mv, mo, rdy, push;
    int mc;

    tbl[0]  = '{5, 0, 0, 16, 1, 1};
    tbl[1]  = '{1, 0, 0, 12, 1, 1};
    tbl[2]  = '{19, 0, 0, 30, 1, 1};
    tbl[3]  = '{20, 0, 0, 31, 1, 1};
    tbl[4]  = '{21, 0, 0, 21, 2, 1};
    tbl[5]  = '{25, 0, 0, 21, 2, 1};
    tbl[6]  = '{5, 4, 3, 13, 3, 1};
    tbl[7]  = '{5, 10, 2, 18, 3, 1};
    tbl[8]  = '{5, 11, 2, 16, 1, 2};
    tbl[9]  = '{3, 2, 30, 36, 3, 1};
    tbl[10] = '{20, 1, 1, 23, 3, 1};

    do_reset();
    chk("rst_valid", int'(evt.evt_valid), 0);
    chk("rst_code", int'(evt.evt_code), 0);
    chk("rst_ovf", int'(evt.evt_overflow), 0);

    // table of single gestures, ready held high
    for (int i = 0; i < 11; i++) begin
      do_reset();
      tick();
      tick();
      first = -1;
      code = -1;
      n = 0;
      for (int k = 0; k < 60; k++) begin
        btn = (k < tbl[i].h1) ||
              (tbl[i].h2 > 0 &&
               k >= tbl[i].h1 + tbl[i].g &&
               k < tbl[i].h1 + tbl[i].g + tbl[i].h2);
        tick();
        if (evt.evt_valid) begin
          n++;
          if (first < 0) begin
            first = k;
            code = int'(evt.evt_code);
          end
        end
      end
      btn = 1'b0;
      chk($sformatf("tbl%0d_time", i), first, tbl[i].exp_k);
      chk($sformatf("tbl%0d_code", i), code, tbl[i].exp_code);
      chk($sformatf("tbl%0d_count", i), n, tbl[i].exp_n);
    end

    // overflow: short held in slot, long dropped
    do_reset();
    evt.evt_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      btn = (k < 5) || (k >= 30 && k < 55);
      tick();
    end
    chk("ovf_valid", int'(evt.evt_valid), 1);
    chk("ovf_code", int'(evt.evt_code), 1);
    chk("ovf_flag", int'(evt.evt_overflow), 1);
    btn = 1'b0;
    evt.evt_ready = 1'b1;
    tick();
    chk("ovf_drain_valid", int'(evt.evt_valid), 0);
    chk("ovf_sticky", int'(evt.evt_overflow), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_rst_clear", int'(evt.evt_overflow), 0);

    // reset in the middle of a held press
    do_reset();
    n = 0;
    for (int k = 0; k < 9; k++) begin
      btn = 1'b1;
      tick();
      if (evt.evt_valid) n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    first = -1;
    code = -1;
    for (int j = 0; j < 40; j++) begin
      btn = 1'b1;
      tick();
      if (evt.evt_valid && first < 0) begin
        first = j;
        code = int'(evt.evt_code);
      end
    end
    btn = 1'b0;
    tick();
    chk("midrst_no_evt", n, 0);
    chk("midrst_time", first, LC + 1);
    chk("midrst_code", code, 2);

    // long hold, with or without auto-repeat
    do_reset();
    ek.delete();
    ec.delete();
    gk.delete();
    gc.delete();
    ek.push_back(LC + 1);
    ec.push_back(2);
`ifdef HOLD_REPEAT_EN
    for (int r = LC + RC; r < 40; r += RC) begin
      ek.push_back(r + 1);
      ec.push_back(0);
    end
`endif
    for (int k = 0; k < 70; k++) begin
      btn = (k < 40);
      tick();
      if (evt.evt_valid) begin
        gk.push_back(k);
        gc.push_back(int'(evt.evt_code));
      end
    end
    chk("hold_count", gk.size(), ek.size());
    for (int i = 0; i < ek.size(); i++) begin
      if (i < gk.size()) begin
        chk($sformatf("hold%0d_time", i), gk[i], ek[i]);
        chk($sformatf("hold%0d_code", i), gc[i], ec[i]);
      end
    end

    // random waveform, event times from press/gap run lengths
    n = 0;
    for (int i = 0; i < 3; i++) b[n++] = 1'b0;
    while (n < NC - 80) begin
      t = $urandom_range(1, LC + 2 * RC + 4);
      for (int i = 0; i < t; i++) b[n++] = 1'b1;
      if ($urandom_range(0, 3) == 0)
        t = $urandom_range(GC + 1, GC + 6);
      else
        t = $urandom_range(1, GC + 2);
      for (int i = 0; i < t; i++) b[n++] = 1'b0;
    end
    while (n < NC) b[n++] = 1'b0;
    for (int i = 0; i < NC; i++) ev[i] = -1;
    ps.delete();
    pl.delete();
    for (int i = 1; i < NC; i++) begin
      if (b[i] && !b[i-1]) begin
        ps.push_back(i);
        pl.push_back(0);
      end
      if (b[i]) pl[pl.size()-1]++;
    end
    n = 0;
    while (n < ps.size()) begin
      if (pl[n] > LC) begin
        ev[ps[n] + LC] = 2;
`ifdef HOLD_REPEAT_EN
        for (int r = ps[n] + LC + RC; r < ps[n] + pl[n]; r += RC)
          ev[r] = 0;
`endif
        n++;
      end else if (n + 1 < ps.size() &&
                   ps[n+1] - (ps[n] + pl[n]) <= GC) begin
        ev[ps[n+1] + pl[n+1]] = 3;
        n += 2;
      end else begin
        ev[ps[n] + pl[n] + GC] = 1;
        n++;
      end
    end

    do_reset();
    mv = 1'b0;
    mo = 1'b0;
    mc = 0;
    for (int i = 0; i < NC; i++) begin
      btn = b[i];
      rdy = ($urandom_range(0, 3) != 0);
      evt.evt_ready = rdy;
      tick();
      push = (i >= 1) && (ev[i-1] >= 0);
      if (push) begin
        if (mv && !rdy) mo = 1'b1;
        else begin
          mv = 1'b1;
          mc = ev[i-1];
        end
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      chk($sformatf("rnd%0d_valid", i), int'(evt.evt_valid), int'(mv));
      chk($sformatf("rnd%0d_code", i), int'(evt.evt_code), mc);
      chk($sformatf("rnd%0d_ovf", i), int'(evt.evt_overflow), int'(mo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
